// File: rtl/sram_arb_pkg.sv
// Shared types and helpers for the SRAM port arbiter.
// Imported by sram_arb_rr_pick and sram_port_arbiter.
package sram_arb_pkg;

  typedef logic [2:0] port_idx_t;

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCKED
  } arb_state_e;

  function automatic logic [7:0] strb2mask(input logic strb);
    return {8{strb}};
  endfunction

  // Compared one bit wider than the operands so base+span cannot wrap.
  function automatic logic in_range(
    input logic [63:0] addr,
    input logic [63:0] base,
    input logic [63:0] words,
    input logic [63:0] bpw
  );
    logic [64:0] a;
    logic [64:0] lo;
    logic [64:0] hi;
    a  = {1'b0, addr};
    lo = {1'b0, base};
    hi = lo + {1'b0, words * bpw};
    return (a >= lo) && (a < hi);
  endfunction

  function automatic port_idx_t port_inc(
    input port_idx_t idx,
    input int        n
  );
    if (int'(idx) >= n - 1) return '0;
    return idx + 3'd1;
  endfunction

endpackage

// File: rtl/sram_arb_rr_pick.sv
// Round-robin picker: first requester at or after ptr_i, wrapping.
// Purely combinational; returns one-hot grant plus its index.
module sram_arb_rr_pick
  import sram_arb_pkg::*;
#(
  parameter int NumPorts = 2
) (
  input  logic [NumPorts-1:0] req_i,
  input  port_idx_t           ptr_i,
  output logic [NumPorts-1:0] gnt_o,
  output port_idx_t           idx_o,
  output logic                valid_o
);

  int p;

  // Scan ports starting at the pointer and keep the first hit.
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    p       = 0;
    for (int i = 0; i < NumPorts; i++) begin
      p = (int'(ptr_i) + i) % NumPorts;
      if (!valid_o && req_i[p]) begin
        valid_o  = 1'b1;
        gnt_o[p] = 1'b1;
        idx_o    = port_idx_t'(p);
      end
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one 1-cycle-latency SRAM between NumPorts requesters.
// Define SRAM_ARB_PERF_EN to add grant/stall perf counters.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int                   NumPorts  = 2,
  parameter int                   AddrWidth = 32,
  parameter int                   DataWidth = 64,
  parameter int                   NumWords  = 1 << 20,
  parameter logic [AddrWidth-1:0] BaseAddr  = 'h8000_0000,
  parameter int                   MaxHold   = 16,
  localparam int                  StrbWidth = DataWidth / 8,
  localparam int                  SramAw    = $clog2(NumWords)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NumPorts-1:0]            req_i,
  input  logic [NumPorts-1:0]            we_i,
  input  logic [NumPorts-1:0]            lock_i,
  input  logic [NumPorts*AddrWidth-1:0]  addr_i,
  input  logic [NumPorts*DataWidth-1:0]  wdata_i,
  input  logic [NumPorts*StrbWidth-1:0]  strb_i,
  output logic [NumPorts-1:0]            gnt_o,
  output logic [NumPorts-1:0]            rvalid_o,
  output logic [DataWidth-1:0]           rdata_o,
  output logic                           err_o,
  output logic                           sram_req_o,
  output logic                           sram_we_o,
  output logic [SramAw-1:0]              sram_addr_o,
  output logic [DataWidth-1:0]           sram_wdata_o,
  output logic [DataWidth-1:0]           sram_wmask_o,
  input  logic [DataWidth-1:0]           sram_rdata_i
`ifdef SRAM_ARB_PERF_EN
  ,
  output logic [NumPorts*32-1:0]         perf_gnt_cnt_o,
  output logic [31:0]                    perf_stall_cnt_o
`endif
);

  localparam int HoldW  = $clog2(MaxHold + 1);
  localparam int OffLsb = $clog2(StrbWidth);

  arb_state_e          state_q, state_d;
  port_idx_t           owner_q, owner_d;
  port_idx_t           rr_ptr_q, rr_ptr_d;
  logic [HoldW-1:0]    hold_q, hold_d, hold_inc;
  logic [NumPorts-1:0] rvalid_q, rvalid_d;
  logic                rd_q, rd_d;
  logic                err_q, err_d;

  logic [NumPorts-1:0] rr_gnt;
  port_idx_t           rr_idx;
  logic                rr_valid;

  logic [NumPorts-1:0] owner_oh;
  logic                locked_hit;
  logic [NumPorts-1:0] gnt;
  port_idx_t           win_idx;
  logic                any_gnt;
  logic                lock_win;

  logic [AddrWidth-1:0] addr_sel;
  logic [DataWidth-1:0] wdata_sel;
  logic [StrbWidth-1:0] strb_sel;
  logic                 we_sel;
  logic                 hit;
  logic [AddrWidth-1:0] byte_off;
  logic [AddrWidth-1:0] word_full;
  logic [DataWidth-1:0] mask;
  logic                 addr_unused;

  sram_arb_rr_pick #(.NumPorts(NumPorts)) u_pick (
    .req_i   (req_i),
    .ptr_i   (rr_ptr_q),
    .gnt_o   (rr_gnt),
    .idx_o   (rr_idx),
    .valid_o (rr_valid)
  );

  // Locked owner wins outright while it requests; else round-robin.
  always_comb begin
    owner_oh = '0;
    for (int i = 0; i < NumPorts; i++) begin
      owner_oh[i] = (port_idx_t'(i) == owner_q);
    end
    locked_hit = (state_q == ARB_LOCKED) && |(req_i & owner_oh);
    gnt        = locked_hit ? owner_oh : rr_gnt;
    win_idx    = locked_hit ? owner_q : rr_idx;
    any_gnt    = locked_hit | rr_valid;
    lock_win   = |(lock_i & gnt);
  end

  // Mux the winner's request fields toward the SRAM.
  always_comb begin
    addr_sel  = '0;
    wdata_sel = '0;
    strb_sel  = '0;
    we_sel    = 1'b0;
    for (int i = 0; i < NumPorts; i++) begin
      if (gnt[i]) begin
        addr_sel  = addr_i[i*AddrWidth +: AddrWidth];
        wdata_sel = wdata_i[i*DataWidth +: DataWidth];
        strb_sel  = strb_i[i*StrbWidth +: StrbWidth];
        we_sel    = we_i[i];
      end
    end
  end

  // Range check, word index and byte-to-bit mask expansion.
  always_comb begin
    hit = in_range(64'(addr_sel), 64'(BaseAddr),
                   64'(NumWords), 64'(StrbWidth));
    byte_off  = addr_sel - BaseAddr;
    word_full = byte_off >> OffLsb;
    mask      = '0;
    for (int i = 0; i < StrbWidth; i++) begin
      mask[i*8 +: 8] = strb2mask(strb_sel[i]);
    end
  end

  assign addr_unused = ^word_full;

  assign gnt_o        = gnt;
  assign sram_req_o   = any_gnt & hit;
  assign sram_we_o    = sram_req_o & we_sel;
  assign sram_addr_o  = sram_req_o ? word_full[SramAw-1:0] : '0;
  assign sram_wdata_o = sram_we_o ? wdata_sel : '0;
  assign sram_wmask_o = sram_we_o ? mask : '0;

  assign rvalid_o = rvalid_q;
  assign err_o    = err_q;
  assign rdata_o  = rd_q ? sram_rdata_i : '0;

  // Lock/hold bookkeeping, rr pointer advance and response capture.
  always_comb begin
    state_d  = ARB_IDLE;
    owner_d  = owner_q;
    hold_d   = '0;
    rr_ptr_d = rr_ptr_q;
    hold_inc = hold_q + HoldW'(1);
    if (locked_hit) begin
      rr_ptr_d = port_inc(owner_q, NumPorts);
      if (lock_win && (hold_inc < HoldW'(MaxHold))) begin
        state_d = ARB_LOCKED;
        hold_d  = hold_inc;
      end
    end else if (rr_valid) begin
      rr_ptr_d = port_inc(rr_idx, NumPorts);
      if ((state_q == ARB_IDLE) && lock_win && (MaxHold > 1)) begin
        state_d = ARB_LOCKED;
        owner_d = win_idx;
        hold_d  = HoldW'(1);
      end
    end
    rvalid_d = gnt;
    rd_d     = any_gnt & hit & ~we_sel;
    err_d    = any_gnt & ~hit;
  end

  // Arbiter state and response registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ARB_IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      hold_q   <= '0;
      rvalid_q <= '0;
      rd_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      hold_q   <= hold_d;
      rvalid_q <= rvalid_d;
      rd_q     <= rd_d;
      err_q    <= err_d;
    end
  end

`ifdef SRAM_ARB_PERF_EN
  logic [NumPorts*32-1:0] gnt_cnt_q, gnt_cnt_d;
  logic [31:0]            stall_cnt_q, stall_cnt_d;

  // Saturating per-port grant and global stall counters.
  always_comb begin
    gnt_cnt_d   = gnt_cnt_q;
    stall_cnt_d = stall_cnt_q;
    for (int i = 0; i < NumPorts; i++) begin
      if (gnt[i] && (gnt_cnt_q[i*32 +: 32] != 32'hFFFF_FFFF)) begin
        gnt_cnt_d[i*32 +: 32] = gnt_cnt_q[i*32 +: 32] + 32'd1;
      end
    end
    if (|(req_i & ~gnt) && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      gnt_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      gnt_cnt_q   <= gnt_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign perf_gnt_cnt_o   = gnt_cnt_q;
  assign perf_stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter (2 ports, MaxHold=4).
// Perf counter checks run when SRAM_ARB_PERF_EN is defined.
module tb_sram_port_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [1:0]  req_i, we_i, lock_i;
  logic [31:0] addr0, addr1;
  logic [63:0] wdata1;
  logic [7:0]  strb1;
  logic [63:0] addr_i;
  logic [127:0] wdata_i;
  logic [15:0] strb_i;
  logic [1:0]  gnt_o, rvalid_o;
  logic [63:0] rdata_o;
  logic        err_o, sram_req_o, sram_we_o;
  logic [19:0] sram_addr_o;
  logic [63:0] sram_wdata_o, sram_wmask_o, sram_rdata_i;
`ifdef SRAM_ARB_PERF_EN
  logic [63:0] perf_gnt_cnt_o;
  logic [31:0] perf_stall_cnt_o;
`endif

  int n_cmp = 0;
  int n_err = 0;

  assign addr_i  = {addr1, addr0};
  assign wdata_i = {wdata1, 64'h0101_0101_0101_0101};
  assign strb_i  = {strb1, 8'hFF};

  always #5 clk_i = ~clk_i;

  sram_port_arbiter #(
    .NumPorts(2), .AddrWidth(32), .DataWidth(64),
    .NumWords(1 << 20), .BaseAddr(32'h8000_0000), .MaxHold(4)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_i(req_i), .we_i(we_i), .lock_i(lock_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .strb_i(strb_i),
    .gnt_o(gnt_o), .rvalid_o(rvalid_o),
    .rdata_o(rdata_o), .err_o(err_o),
    .sram_req_o(sram_req_o), .sram_we_o(sram_we_o),
    .sram_addr_o(sram_addr_o), .sram_wdata_o(sram_wdata_o),
    .sram_wmask_o(sram_wmask_o), .sram_rdata_i(sram_rdata_i)
`ifdef SRAM_ARB_PERF_EN
    ,
    .perf_gnt_cnt_o(perf_gnt_cnt_o),
    .perf_stall_cnt_o(perf_stall_cnt_o)
`endif
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic [1:0]  rq,
                     input logic [1:0]  we,
                     input logic [1:0]  lk,
                     input logic [31:0] a0,
                     input logic [31:0] a1,
                     input logic [63:0] wd,
                     input logic [7:0]  st,
                     input logic [63:0] rd);
    @(negedge clk_i);
    req_i = rq; we_i = we; lock_i = lk;
    addr0 = a0; addr1 = a1; wdata1 = wd; strb1 = st;
    sram_rdata_i = rd;
    #1;
  endtask

  task automatic idle(input logic [63:0] rd);
    cyc(2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 64'h0, 8'h00, rd);
  endtask

  task automatic rr(input logic [1:0] rq, input logic [1:0] lk);
    cyc(rq, 2'b00, lk, 32'h8000_0000, 32'h8000_0000,
        64'h0, 8'hFF, 64'h0);
  endtask

  localparam logic [63:0] Rd0 = 64'hA5A5_0000_0000_5A5A;
  localparam logic [63:0] Rd1 = 64'h1122_3344_5566_7788;
  localparam logic [63:0] Ones = 64'hFFFF_FFFF_FFFF_FFFF;

  initial begin
    rst_i = 1'b1;
    req_i = '0; we_i = '0; lock_i = '0;
    addr0 = '0; addr1 = '0; wdata1 = '0; strb1 = '0;
    sram_rdata_i = '0;

    idle(64'hDEAD);
    idle(64'hDEAD);
    chk("rst_gnt", gnt_o, 2'b00);
    chk("rst_rvalid", rvalid_o, 2'b00);
    chk("rst_sreq", sram_req_o, 1'b0);
    chk("rst_err", err_o, 1'b0);
    chk("rst_rdata", rdata_o, 64'h0);
    chk("rst_wmask", sram_wmask_o, 64'h0);
    rst_i = 1'b0;

    rr(2'b11, 2'b00);
    chk("c1_gnt", gnt_o, 2'b01);
    cyc(2'b11, 2'b00, 2'b00, 32'h8000_0000, 32'h8000_0000,
        64'h0, 8'hFF, Rd0);
    chk("c2_gnt", gnt_o, 2'b10);
    chk("c2_rvalid", rvalid_o, 2'b01);
    chk("c2_rdata", rdata_o, Rd0);

    cyc(2'b01, 2'b00, 2'b00, 32'h8000_0008, 32'h0,
        64'h0, 8'h00, 64'h0);
    chk("rd_gnt", gnt_o, 2'b01);
    chk("rd_sreq", sram_req_o, 1'b1);
    chk("rd_swe", sram_we_o, 1'b0);
    chk("rd_saddr", sram_addr_o, 20'd1);
    chk("c3_rvalid", rvalid_o, 2'b10);

    cyc(2'b10, 2'b10, 2'b00, 32'h0, 32'h8000_0010,
        64'hCAFE_F00D_1234_5678, 8'h0F, Rd1);
    chk("rd_rvalid", rvalid_o, 2'b01);
    chk("rd_rdata", rdata_o, Rd1);
    chk("wr_gnt", gnt_o, 2'b10);
    chk("wr_swe", sram_we_o, 1'b1);
    chk("wr_saddr", sram_addr_o, 20'd2);
    chk("wr_wmask", sram_wmask_o, 64'h0000_0000_FFFF_FFFF);
    chk("wr_wdata", sram_wdata_o, 64'hCAFE_F00D_1234_5678);

    cyc(2'b01, 2'b00, 2'b00, 32'h7FFF_FFF8, 32'h0,
        64'h0, 8'h00, Ones);
    chk("lo_gnt", gnt_o, 2'b01);
    chk("lo_sreq", sram_req_o, 1'b0);
    chk("wr_rvalid", rvalid_o, 2'b10);
    chk("wr_rdata", rdata_o, 64'h0);
    chk("wr_err", err_o, 1'b0);

    cyc(2'b01, 2'b00, 2'b00, 32'h8080_0000, 32'h0,
        64'h0, 8'h00, Ones);
    chk("hi_gnt", gnt_o, 2'b01);
    chk("hi_sreq", sram_req_o, 1'b0);
    chk("lo_rvalid", rvalid_o, 2'b01);
    chk("lo_err", err_o, 1'b1);
    chk("lo_rdata", rdata_o, 64'h0);

    idle(Ones);
    chk("idle_gnt", gnt_o, 2'b00);
    chk("hi_rvalid", rvalid_o, 2'b01);
    chk("hi_err", err_o, 1'b1);
    chk("hi_rdata", rdata_o, 64'h0);
    idle(Ones);
    chk("idle_rvalid", rvalid_o, 2'b00);
    chk("idle_err", err_o, 1'b0);

    rr(2'b01, 2'b01);
    chk("mr_gnt", gnt_o, 2'b01);
    idle(64'h0);
    chk("mr_pend", rvalid_o, 2'b01);
    rst_i = 1'b1;
    #1;
    chk("mr_drop", rvalid_o, 2'b00);
    idle(64'h0);
    rst_i = 1'b0;

    rr(2'b11, 2'b01); chk("lk1", gnt_o, 2'b01);
    rr(2'b11, 2'b01); chk("lk2", gnt_o, 2'b01);
    rr(2'b11, 2'b01); chk("lk3", gnt_o, 2'b01);
    rr(2'b11, 2'b01); chk("lk4", gnt_o, 2'b01);
    rr(2'b11, 2'b01); chk("lk5_max", gnt_o, 2'b10);
    rr(2'b11, 2'b01); chk("lk6", gnt_o, 2'b01);
    rr(2'b11, 2'b00); chk("unlk_own", gnt_o, 2'b01);
    rr(2'b11, 2'b00); chk("unlk_rr", gnt_o, 2'b10);
    rr(2'b01, 2'b01); chk("lk_again", gnt_o, 2'b01);
    rr(2'b10, 2'b00); chk("own_gone", gnt_o, 2'b10);
    rr(2'b11, 2'b01); chk("after_gone", gnt_o, 2'b01);

`ifdef SRAM_ARB_PERF_EN
    rst_i = 1'b1;
    idle(64'h0);
    chk("pf_rst_gnt", perf_gnt_cnt_o, 64'h0);
    chk("pf_rst_stall", perf_stall_cnt_o, 32'd0);
    rst_i = 1'b0;
    rr(2'b10, 2'b10);
    rr(2'b11, 2'b10); chk("pf_g2", gnt_o, 2'b10);
    rr(2'b11, 2'b10); chk("pf_g3", gnt_o, 2'b10);
    rr(2'b11, 2'b00); chk("pf_g4", gnt_o, 2'b10);
    for (int i = 0; i < 6; i++) rr(2'b10, 2'b00);
    idle(64'h0);
    chk("pf_cnt1", perf_gnt_cnt_o[63:32], 32'd10);
    chk("pf_cnt0", perf_gnt_cnt_o[31:0], 32'd0);
    chk("pf_stall", perf_stall_cnt_o, 32'd3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
